direction_decoder: RTL and testbench
====================================

DIRECTION_DECODER -- requirements
Module: direction_decoder

Interface
REQ-001 Parameter: CNT_W, default 8, width of step_count.
REQ-002 Parameter: LOCK_STEPS, default 2, consecutive same-direction steps required before dir_valid asserts.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 y_in  input  3  mod-5 up/down counter code, legal range 0..4, sampled every cycle.
REQ-006 dir  output  1  decoded direction; 1 = up (incrementing), 0 = down.
REQ-007 dir_valid  output  1  high while the direction is locked.
REQ-008 reversal  output  1  one-cycle pulse on a locked direction change.
REQ-009 err  output  1  one-cycle pulse on an illegal code or an illegal transition.
REQ-010 step_count  output  CNT_W  legal steps since the last lock loss or reversal; saturates.

Function
REQ-011 The block shall register y_in into prev_y each cycle; every comparison shall use y_in against prev_y.
REQ-012 Step classification shall be one of the following:
- UP: y_in == prev_y+1, or prev_y==4 and y_in==0.
- DOWN: y_in == prev_y-1, or prev_y==0 and y_in==4.
- HOLD: y_in == prev_y.
- ILLEGAL: y_in > 4, or any other delta.
REQ-013 The FSM shall have states ACQ, TRACK, LOCKED.
REQ-014 ACQ: no valid prev_y. The block shall capture y_in and move to TRACK if y_in <= 4; otherwise it shall pulse err and stay in ACQ.
REQ-015 TRACK, on UP/DOWN matching cand_dir: step_count shall increment. When step_count reaches LOCK_STEPS the FSM shall go to LOCKED, set dir = cand_dir, and assert dir_valid.
REQ-016 TRACK, on UP/DOWN opposite cand_dir: cand_dir shall be replaced and step_count shall be set to 1. No reversal pulse is issued.
REQ-017 The first step after ACQ shall set cand_dir and set step_count = 1.
REQ-018 HOLD in any state shall change no state; counts and outputs shall be held.
REQ-019 LOCKED, on a step in dir: step_count shall increment, saturating at 2^CNT_W-1.
REQ-020 LOCKED, on a step opposite dir: dir shall flip, reversal shall pulse for one cycle, step_count shall be set to 1, and the FSM shall stay in LOCKED.
REQ-021 ILLEGAL in TRACK or LOCKED shall do all of the following on the same edge:
- pulse err;
- clear dir_valid;
- clear step_count;
- go to ACQ if y_in > 4, else to TRACK with prev_y = y_in and no candidate.
REQ-022 err and reversal shall never assert in the same cycle; ILLEGAL has priority.
REQ-023 All outputs shall be registered. reversal and err shall assert in the cycle after the clock edge at which the offending y_in is sampled, and deassert after one cycle.
REQ-024 Latency from the first legal sample to dir_valid shall be LOCK_STEPS+1 edges, excluding HOLD cycles.

Reset
REQ-025 Asserting reset shall asynchronously force the following, mid-operation included:
- state = ACQ;
- prev_y = 0;
- dir = 1;
- dir_valid = 0;
- reversal = 0;
- err = 0;
- step_count = 0.
REQ-026 The first rising edge after reset deassertion shall be treated as an ACQ sample.

Structure
REQ-027 Package direction_pkg shall hold the state enum {ACQ, TRACK, LOCKED}, the step enum {STEP_HOLD, STEP_UP, STEP_DOWN, STEP_ILLEGAL}, and the constant MAX_CODE = 3'd4.
REQ-028 A combinational sub-module step_classifier(prev_y, y_in) -> step type shall implement REQ-012. It shall be instantiated once.
REQ-029 The top level shall contain only the FSM register, the next-state logic and the output registers.

Verification
REQ-030 Reset, then y_in = 0,0,1,2,3 -> dir_valid rises after the 0->1->2 steps, dir = 1, step_count = 3 after the 2->3 step, err never asserted.
REQ-031 Locked up at y = 4, then y_in 0,4,3,2 -> 4->0 counts as an UP wrap; 0->4 pulses reversal once with dir = 0 and step_count = 1; later steps increment step_count; dir_valid stays high.
REQ-032 Locked, then y_in jumps 1->3 -> err pulses one cycle, dir_valid = 0, step_count = 0, state TRACK. Then 3,4,0 -> relock up.
REQ-033 y_in = 7 while locked -> err pulse, state ACQ. Holding y_in = 7 -> err pulses every cycle; outputs otherwise static.
REQ-034 Locked, then reset asserted asynchronously between clock edges -> all outputs go to their reset values immediately. After release, y_in = 2,1,0 -> lock with dir = 0.
REQ-035 Saturation: CNT_W = 3 with 10 consecutive up steps -> step_count holds at 7 with no wrap.

Source files
------------

// File: rtl/direction_pkg.sv
// direction_pkg
// Shared types and constants for the mod-5 up/down counter direction decoder.
//   state_t  : decoder FSM states (ACQ, TRACK, LOCKED)
//   step_t   : classification of one y_in sample against the previous one
//   MAX_CODE : largest legal counter code
package direction_pkg;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    STEP_HOLD    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  localparam logic [2:0] MAX_CODE = 3'd4;

endpackage

// File: rtl/step_classifier.sv
// step_classifier
// Combinational classification of a counter code transition.
// Ports:
//   prev_y : previous registered code (3 bits)
//   y_in   : current code (3 bits)
//   step   : STEP_HOLD / STEP_UP / STEP_DOWN / STEP_ILLEGAL
module step_classifier
  import direction_pkg::*;
(
  input  logic [2:0] prev_y,
  input  logic [2:0] y_in,
  output step_t      step
);

  logic [2:0] up_code;
  logic [2:0] down_code;

  // Expected codes for a single step in each direction, with the 4<->0 wrap.
  assign up_code   = (prev_y == MAX_CODE) ? 3'd0 : prev_y + 3'd1;
  assign down_code = (prev_y == 3'd0) ? MAX_CODE : prev_y - 3'd1;

  always_comb begin
    step = STEP_ILLEGAL;
    if ((y_in <= MAX_CODE) && (prev_y <= MAX_CODE)) begin
      if (y_in == prev_y) begin
        step = STEP_HOLD;
      end else if (y_in == up_code) begin
        step = STEP_UP;
      end else if (y_in == down_code) begin
        step = STEP_DOWN;
      end
    end
  end

endmodule

// File: rtl/direction_decoder.sv
// direction_decoder
// Decodes counting direction from the code stream of a mod-5 up/down counter.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   y_in       : counter code, legal 0..4, sampled every cycle
//   dir        : 1 = counting up, 0 = counting down
//   dir_valid  : high while the direction is locked
//   reversal   : one-cycle pulse when a locked direction flips
//   err        : one-cycle pulse on an illegal code or transition
//   step_count : legal steps since last lock loss or reversal (saturating)
module direction_decoder
  import direction_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int LOCK_STEPS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       y_in,
  output logic             dir,
  output logic             dir_valid,
  output logic             reversal,
  output logic             err,
  output logic [CNT_W-1:0] step_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [2:0]       prev_y_reg;
  logic             cand_dir_reg, cand_dir_next;
  logic             cand_valid_reg, cand_valid_next;
  logic             dir_reg, dir_next;
  logic             dir_valid_reg, dir_valid_next;
  logic             reversal_reg, reversal_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] step_count_reg, step_count_next;

  step_t            step;
  logic             step_up;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] track_count;

  step_classifier u_classifier (
    .prev_y (prev_y_reg),
    .y_in   (y_in),
    .step   (step)
  );

  assign step_up   = (step == STEP_UP);
  assign count_inc = (step_count_reg == CNT_MAX) ? step_count_reg
                                                 : step_count_reg + CNT_ONE;

  always_comb begin
    state_next      = state_reg;
    cand_dir_next   = cand_dir_reg;
    cand_valid_next = cand_valid_reg;
    dir_next        = dir_reg;
    dir_valid_next  = dir_valid_reg;
    step_count_next = step_count_reg;
    reversal_next   = 1'b0;
    err_next        = 1'b0;
    track_count     = CNT_ONE;

    case (state_reg)
      ACQ: begin
        // No trustworthy prev_y yet; only the code range can be judged.
        if (y_in > MAX_CODE) begin
          err_next = 1'b1;
        end else begin
          state_next      = TRACK;
          cand_valid_next = 1'b0;
        end
      end

      TRACK, LOCKED: begin
        case (step)
          STEP_HOLD: begin
          end
          STEP_ILLEGAL: begin
            err_next        = 1'b1;
            dir_valid_next  = 1'b0;
            step_count_next = '0;
            cand_valid_next = 1'b0;
            state_next      = (y_in > MAX_CODE) ? ACQ : TRACK;
          end
          default: begin
            if (state_reg == TRACK) begin
              // A step against the candidate restarts the run silently.
              if (cand_valid_reg && (cand_dir_reg == step_up)) begin
                track_count = count_inc;
              end
              cand_dir_next   = step_up;
              cand_valid_next = 1'b1;
              step_count_next = track_count;
              if (32'(track_count) >= LOCK_STEPS) begin
                state_next     = LOCKED;
                dir_next       = step_up;
                dir_valid_next = 1'b1;
              end
            end else if (step_up == dir_reg) begin
              step_count_next = count_inc;
            end else begin
              dir_next        = step_up;
              reversal_next   = 1'b1;
              step_count_next = CNT_ONE;
            end
          end
        endcase
      end

      default: begin
        state_next = ACQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ACQ;
      prev_y_reg     <= 3'd0;
      cand_dir_reg   <= 1'b1;
      cand_valid_reg <= 1'b0;
      dir_reg        <= 1'b1;
      dir_valid_reg  <= 1'b0;
      reversal_reg   <= 1'b0;
      err_reg        <= 1'b0;
      step_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      prev_y_reg     <= y_in;
      cand_dir_reg   <= cand_dir_next;
      cand_valid_reg <= cand_valid_next;
      dir_reg        <= dir_next;
      dir_valid_reg  <= dir_valid_next;
      reversal_reg   <= reversal_next;
      err_reg        <= err_next;
      step_count_reg <= step_count_next;
    end
  end

  assign dir        = dir_reg;
  assign dir_valid  = dir_valid_reg;
  assign reversal   = reversal_reg;
  assign err        = err_reg;
  assign step_count = step_count_reg;

endmodule

// File: tb/tb_direction_decoder.sv
// tb_direction_decoder
// Self-checking bench: directed vector table, a saturation sequence on a
// narrow-counter instance, then randomized codes against a reference model.
module tb_direction_decoder;

  localparam int LOCK = 2;

  logic       clk;
  logic       reset;
  logic [2:0] y_in;

  logic       dir, dir_valid, reversal, err;
  logic [7:0] step_count;
  logic       s_dir, s_dir_valid, s_reversal, s_err;
  logic [2:0] s_step_count;

  int n_checks = 0;
  int n_fail   = 0;

  direction_decoder #(.CNT_W(8), .LOCK_STEPS(LOCK)) dut (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .dir        (dir),
    .dir_valid  (dir_valid),
    .reversal   (reversal),
    .err        (err),
    .step_count (step_count)
  );

  direction_decoder #(.CNT_W(3), .LOCK_STEPS(LOCK)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .dir        (s_dir),
    .dir_valid  (s_dir_valid),
    .reversal   (s_reversal),
    .err        (s_err),
    .step_count (s_step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind 0: apply y and check after the edge; kind 1: async reset mid-cycle
  typedef struct {
    int kind;
    int y;
    int dir;
    int valid;
    int rev;
    int err;
    int cnt;
  } vec_t;

  // Reference model: direction derived from the mod-5 delta of the codes.
  typedef struct {
    int mode;   // 0 acquiring, 1 tracking, 2 locked
    int prev;
    int cand;   // 0 none, +1 up, -1 down
    int dir;
    int valid;
    int rev;
    int err;
    int cnt;
  } mstate_t;

  function automatic vec_t v(int kind, int y, int d, int val, int rv, int er, int c);
    vec_t r;
    r.kind = kind; r.y = y; r.dir = d; r.valid = val; r.rev = rv; r.err = er; r.cnt = c;
    return r;
  endfunction

  function automatic mstate_t model_reset();
    mstate_t m;
    m.mode = 0; m.prev = 0; m.cand = 0; m.dir = 1;
    m.valid = 0; m.rev = 0; m.err = 0; m.cnt = 0;
    return m;
  endfunction

  function automatic mstate_t model_step(mstate_t s, int y, int cmax);
    mstate_t m;
    int d;
    int sd;
    m = s;
    m.rev = 0;
    m.err = 0;
    m.prev = y;
    if (s.mode == 0) begin
      if (y > 4) m.err = 1;
      else begin m.mode = 1; m.cand = 0; end
      return m;
    end
    if (y > 4) begin
      m.err = 1; m.valid = 0; m.cnt = 0; m.mode = 0; m.cand = 0;
      return m;
    end
    d = (y - s.prev + 5) % 5;
    if (d == 0) return m;
    if (d != 1 && d != 4) begin
      m.err = 1; m.valid = 0; m.cnt = 0; m.mode = 1; m.cand = 0;
      return m;
    end
    sd = (d == 1) ? 1 : -1;
    if (s.mode == 1) begin
      if (s.cand == sd) m.cnt = (s.cnt + 1 > cmax) ? cmax : s.cnt + 1;
      else m.cnt = 1;
      m.cand = sd;
      if (m.cnt >= LOCK) begin
        m.mode = 2; m.valid = 1; m.dir = (sd == 1) ? 1 : 0;
      end
    end else begin
      if ((sd == 1) == (s.dir == 1)) m.cnt = (s.cnt + 1 > cmax) ? cmax : s.cnt + 1;
      else begin
        m.dir = 1 - s.dir; m.rev = 1; m.cnt = 1;
      end
    end
    return m;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int y);
    y_in = 3'(y);
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; reset pulses between edges.
  task automatic async_reset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    chk({tag, ".dir"},   int'(dir), 1);
    chk({tag, ".valid"}, int'(dir_valid), 0);
    chk({tag, ".rev"},   int'(reversal), 0);
    chk({tag, ".err"},   int'(err), 0);
    chk({tag, ".cnt"},   int'(step_count), 0);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_model(input string tag, input mstate_t m, input mstate_t ms);
    chk({tag, ".dir"},     int'(dir), m.dir);
    chk({tag, ".valid"},   int'(dir_valid), m.valid);
    chk({tag, ".rev"},     int'(reversal), m.rev);
    chk({tag, ".err"},     int'(err), m.err);
    chk({tag, ".cnt"},     int'(step_count), m.cnt);
    chk({tag, ".s_valid"}, int'(s_dir_valid), ms.valid);
    chk({tag, ".s_dir"},   int'(s_dir), ms.dir);
    chk({tag, ".s_cnt"},   int'(s_step_count), ms.cnt);
    chk({tag, ".err_rev_excl"}, int'(err & reversal), 0);
  endtask

  vec_t    vecs[$];
  mstate_t m_main, m_sat;

  initial begin
    reset = 1'b0;
    y_in  = 3'd0;

    // Directed vectors for LOCK_STEPS = 2, CNT_W = 8.
    //           kind y  dir val rev err cnt
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0));  // ACQ sample
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0));  // hold
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(v(0, 2, 1, 1, 0, 0, 2));  // lock up
    vecs.push_back(v(0, 3, 1, 1, 0, 0, 3));
    vecs.push_back(v(0, 4, 1, 1, 0, 0, 4));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 5));  // 4->0 wraps up
    vecs.push_back(v(0, 4, 0, 1, 1, 0, 1));  // reversal
    vecs.push_back(v(0, 3, 0, 1, 0, 0, 2));
    vecs.push_back(v(0, 2, 0, 1, 0, 0, 3));
    vecs.push_back(v(0, 1, 0, 1, 0, 0, 4));
    vecs.push_back(v(0, 3, 0, 0, 0, 1, 0));  // 1->3 illegal jump
    vecs.push_back(v(0, 3, 0, 0, 0, 0, 0));  // hold in TRACK
    vecs.push_back(v(0, 4, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 2));  // relock up
    vecs.push_back(v(0, 7, 1, 0, 0, 1, 0));  // bad code -> ACQ
    vecs.push_back(v(0, 7, 1, 0, 0, 1, 0));
    vecs.push_back(v(0, 7, 1, 0, 0, 1, 0));
    vecs.push_back(v(0, 2, 1, 0, 0, 0, 0));  // ACQ capture
    vecs.push_back(v(0, 3, 1, 0, 0, 0, 1));  // candidate up
    vecs.push_back(v(0, 2, 1, 0, 0, 0, 1));  // candidate replaced, no pulse
    vecs.push_back(v(0, 1, 0, 1, 0, 0, 2));  // lock down
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 0));  // async reset while locked
    vecs.push_back(v(0, 2, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 2));  // lock down after reset
    vecs.push_back(v(0, 2, 0, 0, 0, 1, 0));  // 0->2 illegal, no reversal

    repeat (2) @(posedge clk);
    #1;
    chk("rst.dir",   int'(dir), 1);
    chk("rst.valid", int'(dir_valid), 0);
    chk("rst.rev",   int'(reversal), 0);
    chk("rst.err",   int'(err), 0);
    chk("rst.cnt",   int'(step_count), 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].kind == 1) begin
        async_reset($sformatf("vec%0d.areset", i));
      end else begin
        tick(vecs[i].y);
        chk($sformatf("vec%0d.dir", i),   int'(dir), vecs[i].dir);
        chk($sformatf("vec%0d.valid", i), int'(dir_valid), vecs[i].valid);
        chk($sformatf("vec%0d.rev", i),   int'(reversal), vecs[i].rev);
        chk($sformatf("vec%0d.err", i),   int'(err), vecs[i].err);
        chk($sformatf("vec%0d.cnt", i),   int'(step_count), vecs[i].cnt);
      end
    end
    $display("directed table: %0d vectors applied", vecs.size());

    // Saturation: ten consecutive up steps on the 3-bit counter instance.
    async_reset("sat.areset");
    tick(0);
    for (int k = 1; k <= 10; k++) begin
      tick(k % 5);
      chk($sformatf("sat.step%0d.s_cnt", k), int'(s_step_count), (k > 7) ? 7 : k);
      chk($sformatf("sat.step%0d.cnt", k),   int'(step_count), k);
      $display("sat step %0d: y=%0d s_cnt=%0d cnt=%0d", k, k % 5, s_step_count, step_count);
    end
    chk("sat.s_valid", int'(s_dir_valid), 1);
    chk("sat.s_dir",   int'(s_dir), 1);

    // Randomized codes against the reference model on both instances.
    async_reset("rnd.areset0");
    m_main = model_reset();
    m_sat  = model_reset();
    begin
      int last_y;
      int y;
      int r;
      last_y = 0;
      for (int c = 0; c < 3000; c++) begin
        r = int'($urandom_range(0, 199));
        if (r == 0) begin
          async_reset($sformatf("rnd%0d.areset", c));
          m_main = model_reset();
          m_sat  = model_reset();
          continue;
        end
        r = int'($urandom_range(0, 99));
        if (last_y > 4)   y = int'($urandom_range(0, 4));
        else if (r < 40)  y = (last_y + 1) % 5;
        else if (r < 70)  y = (last_y + 4) % 5;
        else if (r < 85)  y = last_y;
        else              y = int'($urandom_range(0, 7));
        tick(y);
        m_main = model_step(m_main, y, 255);
        m_sat  = model_step(m_sat, y, 7);
        check_model($sformatf("rnd%0d", c), m_main, m_sat);
        if (c % 500 == 0)
          $display("rnd %0d: y=%0d dir=%0d valid=%0d cnt=%0d", c, y, dir, dir_valid, step_count);
        last_y = y;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
